gravity_lock_scheduler: RTL and testbench
=========================================

Name: gravity_lock_scheduler

Overview:
- Tetris game controller. Generates the timed DOWN (gravity) and LOCK requests for the game state machine.
- Gravity interval depends on level, with an optional soft-drop speed-up.
- Manages the lock-delay window once the piece is grounded, with a bounded number of lock-timer resets.
- Requests go out over a valid/ready handshake into the command queue alongside the UART, button and switch commands.

Parameters:
- BASE_TICK, 50_000_000: gravity interval at level 0, in clk cycles.
- STEP_TICK, 3_000_000: interval reduction per level.
- MIN_TICK, 2_500_000: floor on the gravity interval.
- LOCK_TICK, 25_000_000: lock-delay length in cycles.
- MAX_LOCK_RESETS, 15: lock-timer resets allowed per piece; max 15.
- SOFT_SHIFT, 3: soft-drop interval right-shift.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- enable  in  1  game running; 0 forces IDLE.
- level  in  4  current level, 0-15.
- spawn  in  1  pulse: new piece placed.
- grounded  in  1  level signal: piece rests on stack or floor.
- moved  in  1  pulse: successful move or rotate while grounded.
- soft_drop  in  1  level signal: soft-drop held.
- req_ready  in  1  command queue accepts a request.
- req_valid  out  1  request pending.
- req_kind  out  1  0 = DOWN, 1 = LOCK.
- lock_active  out  1  lock timer running.
- lock_resets_left  out  4  remaining lock resets.

Behaviour:
- Reset values: req_valid=0, req_kind=0, lock_active=0, lock_resets_left=MAX_LOCK_RESETS, state IDLE, all counters 0.
- reset has priority over every other input. Asserting reset mid-handshake drops req_valid on the next cycle with no acceptance.
- Interval (combinational): level*STEP_TICK >= BASE_TICK-MIN_TICK ? MIN_TICK : BASE_TICK - level*STEP_TICK.
  - Computed without unsigned underflow.
  - Counter width is clog2(BASE_TICK)+1.
- Soft-drop interval: interval >> SOFT_SHIFT, floored at 1 (optional feature only).
- States: IDLE, FALL, REQ_DOWN, GROUND, REQ_LOCK, WAIT_SPAWN.
- enable=0 in any state: next state IDLE, counters cleared, req_valid=0.
- IDLE: a spawn pulse with enable=1 goes to FALL.
- spawn with enable=1 in any non-IDLE state: next state FALL, gravity count=0, lock count=0, lock_resets_left=MAX. This has priority over everything except reset and enable=0.
- FALL:
  - gcnt increments each cycle.
  - grounded=1: go to GROUND, lock count=0, gcnt held at 0.
  - Otherwise, when gcnt >= interval-1: go to REQ_DOWN, gcnt=0.
  - Net effect: req_valid rises exactly `interval` cycles after the spawn edge.
- Level change mid-count applies immediately. If gcnt already meets the new threshold, the request fires on the next cycle.
- REQ_DOWN:
  - req_valid=1, req_kind=0. Both held stable until req_valid & req_ready, then return to FALL.
  - Counters do not run while waiting.
  - grounded rising while waiting: the request is still completed, then FALL re-evaluates grounded.
- GROUND:
  - lock_active=1, lcnt increments each cycle.
  - moved=1 with lock_resets_left>0: lcnt=0, lock_resets_left decrements.
  - moved=1 with lock_resets_left=0: ignored.
  - grounded=0: return to FALL, gcnt=0, lock_resets_left kept.
  - lcnt >= LOCK_TICK-1: go to REQ_LOCK.
  - moved and lock expiry in the same cycle: the reset wins if any resets remain.
- REQ_LOCK: req_valid=1, req_kind=1, held until accepted, then go to WAIT_SPAWN. lock_active=0.
- WAIT_SPAWN: no requests; wait for spawn.
- At most one request is outstanding at any time. req_valid never drops without acceptance, except on reset or enable=0.

Optional Feature:
- Macro SOFT_DROP_EN.
- Defined: while soft_drop=1 in FALL, the threshold uses the soft-drop interval. Toggling soft_drop mid-count behaves like a level change.
- Undefined: soft_drop is ignored. The port is still present; no shift logic is synthesized.

Test Plan:
All scenarios use BASE_TICK=100, STEP_TICK=10, MIN_TICK=20, LOCK_TICK=30, MAX_LOCK_RESETS=2, SOFT_SHIFT=2.
1. enable=1, level=0, req_ready=1, spawn at T -> DOWN requests at T+100, T+200, T+300, each with req_valid high for 1 cycle.
2. level=9 -> DOWN period 20. level=15 -> period 20 (clamped, no wrap). level changed 0->9 when gcnt=50 -> request on the next cycle.
3. req_ready=0 for 40 cycles during REQ_DOWN -> req_valid=1 and req_kind=0 stable throughout. Accepted on the first ready cycle; the next request comes 100 cycles after acceptance.
4. grounded=1 at G, moved pulses at G+20, G+40, G+60 -> lock_resets_left 2->1->0, third pulse ignored. LOCK request at G+70, then WAIT_SPAWN until spawn.
5. reset pulse during REQ_LOCK with req_ready=0 -> next cycle req_valid=0, lock_resets_left=2, state IDLE. A subsequent spawn restarts the 100-cycle gravity count.
6. SOFT_DROP_EN defined, level=0, soft_drop=1 -> DOWN period 25. Undefined, same stimulus -> period 100.

Source files
------------

// File: rtl/gravity_lock_scheduler_if.sv
// Request handshake between the gravity/lock scheduler and the command queue.
// The scheduler drives the request; the queue drives ready.
interface gravity_lock_scheduler_if;
  logic req_valid;
  logic req_kind;
  logic req_ready;

  modport master (
    output req_valid,
    output req_kind,
    input  req_ready
  );

  modport slave (
    input  req_valid,
    input  req_kind,
    output req_ready
  );
endinterface

// File: rtl/gravity_lock_scheduler.sv
// Tetris gravity and lock-delay scheduler: issues timed DOWN/LOCK requests over a valid/ready bus.
// Optional macro SOFT_DROP_EN enables the soft-drop shortened gravity interval.
module gravity_lock_scheduler #(
  parameter int unsigned BASE_TICK       = 50_000_000,
  parameter int unsigned STEP_TICK       = 3_000_000,
  parameter int unsigned MIN_TICK        = 2_500_000,
  parameter int unsigned LOCK_TICK       = 25_000_000,
  parameter int unsigned MAX_LOCK_RESETS = 15,
  parameter int unsigned SOFT_SHIFT      = 3
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            enable,
  input  logic [3:0]                      level,
  input  logic                            spawn,
  input  logic                            grounded,
  input  logic                            moved,
  input  logic                            soft_drop,
  gravity_lock_scheduler_if.master        req,
  output logic                            lock_active,
  output logic [3:0]                      lock_resets_left
);

  localparam int unsigned CW = $clog2(BASE_TICK) + 1;
  localparam int unsigned PW = CW + 4;
  localparam int unsigned LW = $clog2(LOCK_TICK) + 1;
  localparam logic [3:0]  MaxResets = 4'(MAX_LOCK_RESETS);

  typedef enum logic [2:0] {
    StIdle,
    StFall,
    StReqDown,
    StGround,
    StReqLock,
    StWaitSpawn
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] gcnt_q, gcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [3:0]    resets_q, resets_d;

  logic [PW-1:0] step_total;
  logic [CW-1:0] interval;
  logic [CW-1:0] threshold;

  // Wide product and compare-before-subtract keep the clamp free of underflow.
  assign step_total = PW'(level) * PW'(STEP_TICK);
  assign interval   = (step_total >= PW'(BASE_TICK - MIN_TICK)) ? CW'(MIN_TICK)
                                                                : CW'(BASE_TICK) - CW'(step_total);

`ifdef SOFT_DROP_EN
  logic [CW-1:0] soft_interval;

  always_comb begin
    soft_interval = interval >> SOFT_SHIFT;
    if (soft_interval == '0) begin
      soft_interval = CW'(1);
    end
  end

  assign threshold = (soft_drop ? soft_interval : interval) - CW'(1);
`else
  logic unused_soft_drop;
  assign unused_soft_drop = soft_drop ^ (SOFT_SHIFT == 0);
  assign threshold        = interval - CW'(1);
`endif

  always_comb begin
    state_d       = state_q;
    gcnt_d        = gcnt_q;
    lcnt_d        = lcnt_q;
    resets_d      = resets_q;
    req.req_valid = 1'b0;
    req.req_kind  = 1'b0;
    lock_active   = 1'b0;

    unique case (state_q)
      StReqDown: req.req_valid = 1'b1;
      StGround:  lock_active   = 1'b1;
      StReqLock: begin
        req.req_valid = 1'b1;
        req.req_kind  = 1'b1;
      end
      default: ;
    endcase

    if (!enable) begin
      state_d  = StIdle;
      gcnt_d   = '0;
      lcnt_d   = '0;
      resets_d = MaxResets;
    end else if (spawn) begin
      state_d  = StFall;
      gcnt_d   = '0;
      lcnt_d   = '0;
      resets_d = MaxResets;
    end else begin
      unique case (state_q)
        StIdle: ;
        StFall: begin
          if (grounded) begin
            state_d = StGround;
            gcnt_d  = '0;
            lcnt_d  = '0;
          end else if (gcnt_q >= threshold) begin
            state_d = StReqDown;
            gcnt_d  = '0;
          end else begin
            gcnt_d = gcnt_q + CW'(1);
          end
        end
        StReqDown: begin
          // The handshake cycle counts as the first cycle of the next interval,
          // so back-to-back DOWN requests stay exactly one interval apart.
          if (req_ready_i_seen()) begin
            state_d = StFall;
            gcnt_d  = CW'(1);
          end
        end
        StGround: begin
          if (!grounded) begin
            state_d = StFall;
            gcnt_d  = '0;
          end else if (moved && (resets_q != '0)) begin
            lcnt_d   = '0;
            resets_d = resets_q - 4'd1;
          end else if (lcnt_q >= LW'(LOCK_TICK - 1)) begin
            state_d = StReqLock;
            lcnt_d  = '0;
          end else begin
            lcnt_d = lcnt_q + LW'(1);
          end
        end
        StReqLock: begin
          if (req_ready_i_seen()) begin
            state_d = StWaitSpawn;
          end
        end
        StWaitSpawn: ;
        default: state_d = StIdle;
      endcase
    end
  end

  function automatic logic req_ready_i_seen();
    return req.req_ready;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      gcnt_q   <= '0;
      lcnt_q   <= '0;
      resets_q <= MaxResets;
    end else begin
      state_q  <= state_d;
      gcnt_q   <= gcnt_d;
      lcnt_q   <= lcnt_d;
      resets_q <= resets_d;
    end
  end

  assign lock_resets_left = resets_q;

endmodule

// File: tb/tb_gravity_lock_scheduler.sv
// Self-checking bench: directed scenarios with literal timing expectations plus randomized
// stimulus, all compared every cycle against a timestamp-based behavioural model.
module tb_gravity_lock_scheduler;

  localparam int BASE  = 100;
  localparam int STEP  = 10;
  localparam int MINT  = 20;
  localparam int LOCK  = 30;
  localparam int MAXR  = 2;
  localparam int SHIFT = 2;
`ifdef SOFT_DROP_EN
  localparam bit SOFT_EN = 1'b1;
`else
  localparam bit SOFT_EN = 1'b0;
`endif

  localparam int MIdle = 0, MFall = 1, MReqDown = 2, MGround = 3, MReqLock = 4, MWait = 5;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [3:0] level;
  logic       spawn;
  logic       grounded;
  logic       moved;
  logic       soft_drop;
  logic       lock_active;
  logic [3:0] lock_resets_left;

  gravity_lock_scheduler_if bus ();

  gravity_lock_scheduler #(
    .BASE_TICK       (BASE),
    .STEP_TICK       (STEP),
    .MIN_TICK        (MINT),
    .LOCK_TICK       (LOCK),
    .MAX_LOCK_RESETS (MAXR),
    .SOFT_SHIFT      (SHIFT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .enable           (enable),
    .level            (level),
    .spawn            (spawn),
    .grounded         (grounded),
    .moved            (moved),
    .soft_drop        (soft_drop),
    .req              (bus.master),
    .lock_active      (lock_active),
    .lock_resets_left (lock_resets_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int now      = 0;

  // Model: mode plus timestamps of when the current gravity / lock window began.
  int m_mode       = MIdle;
  int m_fall_base  = 0;
  int m_lock_base  = 0;
  int m_resets     = MAXR;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, now);
    end
  endtask

  function automatic int model_interval(input int lvl, input bit sd);
    int iv;
    if (lvl * STEP >= BASE - MINT) iv = MINT;
    else iv = BASE - lvl * STEP;
    if (sd && SOFT_EN) begin
      iv = iv >> SHIFT;
      if (iv < 1) iv = 1;
    end
    return iv;
  endfunction

  // Advance the model across the coming clock edge using the inputs now applied.
  task automatic model_step();
    now++;
    if (reset || !enable) begin
      m_mode   = MIdle;
      m_resets = MAXR;
    end else if (spawn) begin
      m_mode      = MFall;
      m_fall_base = now + 1;
      m_resets    = MAXR;
    end else begin
      case (m_mode)
        MFall: begin
          if (grounded) begin
            m_mode      = MGround;
            m_lock_base = now + 1;
          end else if (now - m_fall_base >= model_interval(int'(level), soft_drop) - 1) begin
            m_mode = MReqDown;
          end
        end
        MReqDown: if (bus.req_ready) begin
          m_mode      = MFall;
          m_fall_base = now;
        end
        MGround: begin
          if (!grounded) begin
            m_mode      = MFall;
            m_fall_base = now + 1;
          end else if (moved && m_resets > 0) begin
            m_resets--;
            m_lock_base = now + 1;
          end else if (now - m_lock_base >= LOCK - 1) begin
            m_mode = MReqLock;
          end
        end
        MReqLock: if (bus.req_ready) m_mode = MWait;
        default: ;
      endcase
    end
  endtask

  task automatic check_outputs();
    chk("req_valid", 32'(bus.req_valid), 32'(m_mode == MReqDown || m_mode == MReqLock));
    chk("req_kind", 32'(bus.req_kind), 32'(m_mode == MReqLock));
    chk("lock_active", 32'(lock_active), 32'(m_mode == MGround));
    chk("lock_resets_left", 32'(lock_resets_left), 32'(m_resets));
  endtask

  task automatic tick();
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic wait_rise(input int limit, output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!bus.req_valid && n < limit);
    if (!bus.req_valid) begin
      failures++;
      checks++;
      $display("FAIL wait_rise: no request within %0d cycles (cycle %0d)", limit, now);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    reset = 1'b1; enable = 1'b0; level = 4'd0; spawn = 1'b0;
    grounded = 1'b0; moved = 1'b0; soft_drop = 1'b0; bus.req_ready = 1'b0;
    @(negedge clk);
    repeat (3) tick();
    chk("reset_resets_left", 32'(lock_resets_left), 32'd2);
    chk("reset_req_valid", 32'(bus.req_valid), 32'd0);

    // Level 0 gravity: requests 100 cycles apart, accepted immediately.
    reset = 1'b0; enable = 1'b1; bus.req_ready = 1'b1;
    spawn = 1'b1; tick(); spawn = 1'b0;
    wait_rise(300, n); chk("first_down_latency", n, 100);
    wait_rise(300, n); chk("down_period_l0_a", n, 100);
    wait_rise(300, n); chk("down_period_l0_b", n, 100);

    // Faster levels and the clamp.
    level = 4'd9;
    wait_rise(300, n); chk("down_period_l9", n, 20);
    level = 4'd15;
    wait_rise(300, n); chk("down_period_l15", n, 20);
    level = 4'd7;
    wait_rise(300, n); chk("down_period_l7", n, 30);

    // Level jump while count already past the new threshold.
    tick();
    level = 4'd0; spawn = 1'b1; tick(); spawn = 1'b0;
    repeat (50) tick();
    level = 4'd9; tick();
    chk("level_jump_immediate", 32'(bus.req_valid), 32'd1);

    // Back-pressure: request held stable, next one an interval after acceptance.
    level = 4'd0; tick(); bus.req_ready = 1'b0;
    wait_rise(300, n);
    k = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.req_valid === 1'b1 && bus.req_kind === 1'b0) k++;
    end
    chk("held_down_cycles", k, 40);
    bus.req_ready = 1'b1;
    wait_rise(300, n); chk("gap_after_accept", n, 100);

    // Lock delay with bounded resets.
    tick();
    spawn = 1'b1; tick(); spawn = 1'b0; grounded = 1'b1;
    for (k = 1; k < 200; k++) begin
      moved = (k == 21 || k == 41 || k == 61);
      tick();
      moved = 1'b0;
      if (k == 21) chk("resets_after_move1", 32'(lock_resets_left), 32'd1);
      if (k == 41) chk("resets_after_move2", 32'(lock_resets_left), 32'd0);
      if (k == 61) chk("resets_after_move3", 32'(lock_resets_left), 32'd0);
      if (bus.req_valid) break;
    end
    chk("lock_request_time", k, 71);
    chk("lock_request_kind", 32'(bus.req_kind), 32'd1);
    repeat (30) tick();
    chk("wait_spawn_quiet", 32'(bus.req_valid), 32'd0);

    // Reset while a LOCK request is stalled.
    bus.req_ready = 1'b0;
    spawn = 1'b1; tick(); spawn = 1'b0;
    wait_rise(100, n); chk("lock_delay_plain", n, 31);
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    chk("reset_drops_valid", 32'(bus.req_valid), 32'd0);
    chk("reset_restores_resets", 32'(lock_resets_left), 32'd2);
    grounded = 1'b0; bus.req_ready = 1'b1;
    repeat (3) tick();
    spawn = 1'b1; tick(); spawn = 1'b0;
    wait_rise(300, n); chk("after_reset_latency", n, 100);

    // Soft drop.
    soft_drop = 1'b1;
    wait_rise(300, n);
    wait_rise(300, n); chk("soft_drop_period", n, SOFT_EN ? 25 : 100);
    soft_drop = 1'b0;

    // Randomized stimulus against the model.
    for (int c = 0; c < 6000; c++) begin
      reset         = ($urandom_range(0, 799) == 0);
      enable        = ($urandom_range(0, 299) != 0);
      spawn         = ($urandom_range(0, 149) == 0);
      moved         = ($urandom_range(0, 7) == 0);
      bus.req_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 39) == 0) grounded = ~grounded;
      if ($urandom_range(0, 199) == 0) level = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 99) == 0) soft_drop = ~soft_drop;
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
